vga_timing_ctrl: RTL and testbench

- Display-side end of the pixel interface: generates VGA raster timing (hsync, vsync, blanking) and drives h_addr/v_addr to a pixel source (text renderer, framebuffer reader).
- Samples the source's vga_data after a fixed pipeline latency and drives aligned RGB to the DAC/pins.
- Sits between the pixel source and the top-level VGA pins; one instance per display.

---
 rtl/vga_timing_ctrl.sv | 146 ++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing, pixel addressing and latency-aligned RGB output.
// Build option VGA_TEST_PATTERN_EN replaces vga_data with 8 colour bars.
module vga_timing_ctrl #(
  parameter int H_DISP  = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_DISP  = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int PIX_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  h_addr,
  output logic [9:0]  v_addr,
  input  logic [23:0] vga_data,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic        valid,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_DISP + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_DISP + V_FP;
  localparam int H_ACT   = H_SYNC + H_BP;
  localparam int V_ACT   = V_SYNC + V_BP;

  localparam logic [9:0] H_TOT_M1 = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_TOT_M1 = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYN_W  = 10'(H_SYNC);
  localparam logic [9:0] V_SYN_W  = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_S  = 10'(H_ACT);
  localparam logic [9:0] V_ACT_S  = 10'(V_ACT);
  localparam logic [9:0] H_LAST   = 10'(H_ACT + H_DISP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACT + V_DISP - 1);

`ifdef VGA_TEST_PATTERN_EN
  localparam int PW = 13;
`else
  localparam int PW = 3;
`endif
  // Pipeline word: low bits are {hs, vs, act}; idle is sync high, act low.
  localparam logic [PW-1:0] IDLE = PW'(3'b110);

  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic          hs_raw;
  logic          vs_raw;
  logic          act_raw;
  logic          act_out;
  logic [PW-1:0] raw;
  logic [PW-1:0] dly;
  logic [23:0]   pix;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_TOT_M1) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_TOT_M1) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign hs_raw  = !(h_cnt < H_SYN_W);
  assign vs_raw  = !(v_cnt < V_SYN_W);
  assign act_raw = (h_cnt >= H_ACT_S) && (h_cnt <= H_LAST) &&
                   (v_cnt >= V_ACT_S) && (v_cnt <= V_LAST);
  assign act_out = act_raw && !rst;

  assign h_addr      = act_out ? h_cnt - H_ACT_S : '0;
  assign v_addr      = act_out ? v_cnt - V_ACT_S : '0;
  assign frame_start = (h_cnt == '0) && (v_cnt == '0) && !rst;

`ifdef VGA_TEST_PATTERN_EN
  assign raw = {h_addr, hs_raw, vs_raw, act_raw};
`else
  assign raw = {hs_raw, vs_raw, act_raw};
`endif

  generate
    if (PIX_LAT == 0) begin : g_nolat
      assign dly = raw;
    end else begin : g_lat
      logic [PW-1:0] sr [PIX_LAT];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < PIX_LAT; i++)
            sr[i] <= IDLE;
        end else begin
          sr[0] <= raw;
          for (int i = 1; i < PIX_LAT; i++)
            sr[i] <= sr[i-1];
        end
      end
      assign dly = sr[PIX_LAT-1];
    end
  endgenerate

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_DISP / 8;
  logic [2:0]  bar;
  logic [23:0] unused_data;
  assign unused_data = vga_data;
  assign bar = 3'(dly[12:3] / 10'(BAR_W));

  always_comb begin
    pix = 24'h000000;
    case (bar)
      3'd0:    pix = 24'hFFFFFF;
      3'd1:    pix = 24'hFFFF00;
      3'd2:    pix = 24'h00FFFF;
      3'd3:    pix = 24'h00FF00;
      3'd4:    pix = 24'hFF00FF;
      3'd5:    pix = 24'hFF0000;
      3'd6:    pix = 24'h0000FF;
      default: pix = 24'h000000;
    endcase
  end
`else
  assign pix = vga_data;
`endif

  // Blanking forces RGB to zero so nothing leaks onto the DAC.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      valid <= 1'b0;
      {vga_r, vga_g, vga_b} <= '0;
    end else begin
      hsync <= dly[2];
      vsync <= dly[1];
      valid <= dly[0];
      {vga_r, vga_g, vga_b} <= dly[0] ? pix : 24'h0;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: boundary vector table plus a cycle-index
// reference model exercised with random run lengths and resets.
module tb_vga_timing_ctrl;

  localparam int HD = 16, HF = 2, HS = 3, HB = 4;
  localparam int VD = 6,  VF = 2, VS = 2, VB = 3;
  localparam int PL = 1;
  localparam int L  = PL + 1;
  localparam int HT = HS + HB + HD + HF;
  localparam int VT = VS + VB + VD + VF;
  localparam int HACT = HS + HB;
  localparam int VACT = VS + VB;

  typedef struct packed {
    logic [9:0]  ha;
    logic [9:0]  va;
    logic        fs;
    logic        hs;
    logic        vs;
    logic        vl;
    logic [23:0] rgb;
  } out_t;

  typedef struct {
    int   n;
    out_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  h_addr, v_addr;
  logic [23:0] vga_data;
  logic        frame_start, hsync, vsync, valid;
  logic [7:0]  vga_r, vga_g, vga_b;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int fs_cnt = 0;
  int vs_cnt = 0;

  vga_timing_ctrl #(
    .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIX_LAT(PL)
  ) dut (
    .clk(clk), .rst(rst),
    .h_addr(h_addr), .v_addr(v_addr),
    .vga_data(vga_data),
    .frame_start(frame_start),
    .hsync(hsync), .vsync(vsync), .valid(valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

`ifdef VGA_TEST_PATTERN_EN
  assign vga_data = 24'h123456;
`else
  // Source with a one-cycle registered lookup.
  always @(posedge clk)
    vga_data <= {h_addr[7:0], v_addr[7:0], 8'hA5};
`endif

  function automatic logic [23:0] pix_of(input int x, input int y);
`ifdef VGA_TEST_PATTERN_EN
    case ((x / (HD / 8)) % 8)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
`else
    return {8'(x), 8'(y), 8'hA5};
`endif
  endfunction

  function automatic bit is_act(input int hc, input int vc);
    return hc >= HACT && hc < HACT + HD && vc >= VACT && vc < VACT + VD;
  endfunction

  function automatic out_t idle();
    out_t e;
    e.ha = '0; e.va = '0; e.fs = 1'b0;
    e.hs = 1'b1; e.vs = 1'b1; e.vl = 1'b0; e.rgb = '0;
    return e;
  endfunction

  // Outputs seen n cycles after reset release; sync/RGB reflect position n-L.
  function automatic out_t model(input int m, input bit in_rst);
    out_t e;
    int p, hc, vc;
    e = idle();
    if (in_rst) return e;
    p = m % (HT * VT);
    hc = p % HT;
    vc = p / HT;
    if (is_act(hc, vc)) begin
      e.ha = 10'(hc - HACT);
      e.va = 10'(vc - VACT);
    end
    e.fs = (hc == 0 && vc == 0);
    if (m >= L) begin
      p = (m - L) % (HT * VT);
      hc = p % HT;
      vc = p / HT;
      e.hs = (hc >= HS);
      e.vs = (vc >= VS);
      if (is_act(hc, vc)) begin
        e.vl = 1'b1;
        e.rgb = pix_of(hc - HACT, vc - VACT);
      end
    end
    return e;
  endfunction

  function automatic out_t mk(input int ha, input int va, input bit fs,
                              input bit hs, input bit vs, input bit vl,
                              input logic [23:0] rgb);
    out_t e;
    e.ha = 10'(ha); e.va = 10'(va); e.fs = fs;
    e.hs = hs; e.vs = vs; e.vl = vl; e.rgb = rgb;
    return e;
  endfunction

  task automatic check(input string tag, input out_t exp);
    out_t act;
    act = {h_addr, v_addr, frame_start, hsync, vsync, valid,
           vga_r, vga_g, vga_b};
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20)
        $display("FAIL %s n=%0d: got %h expected %h", tag, n, act, exp);
    end
  endtask

  task automatic run(input int cycles, input bit chk);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (!vsync) vs_cnt++;
      if (frame_start) fs_cnt++;
      if (chk) check("model", model(n, 1'b0));
    end
  endtask

  task automatic hold_rst(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check("rst", model(0, 1'b1));
    end
    rst = 1'b0;
    n = 0;
    #1;
    check("release", model(0, 1'b0));
  endtask

  vec_t tab [18];

  initial begin
    tab[0]  = '{0,   mk(0, 0, 1, 1, 1, 0, 0)};
    tab[1]  = '{1,   mk(0, 0, 0, 1, 1, 0, 0)};
    tab[2]  = '{2,   mk(0, 0, 0, 0, 0, 0, 0)};
    tab[3]  = '{4,   mk(0, 0, 0, 0, 0, 0, 0)};
    tab[4]  = '{5,   mk(0, 0, 0, 1, 0, 0, 0)};
    tab[5]  = '{51,  mk(0, 0, 0, 1, 0, 0, 0)};
    tab[6]  = '{52,  mk(0, 0, 0, 0, 1, 0, 0)};
    tab[7]  = '{132, mk(0, 0, 0, 1, 1, 0, 0)};
    tab[8]  = '{134, mk(2, 0, 0, 1, 1, 1, pix_of(0, 0))};
    tab[9]  = '{136, mk(4, 0, 0, 1, 1, 1, pix_of(2, 0))};
    tab[10] = '{147, mk(15, 0, 0, 1, 1, 1, pix_of(13, 0))};
    tab[11] = '{148, mk(0, 0, 0, 1, 1, 1, pix_of(14, 0))};
    tab[12] = '{149, mk(0, 0, 0, 1, 1, 1, pix_of(15, 0))};
    tab[13] = '{150, mk(0, 0, 0, 1, 1, 0, 0)};
    tab[14] = '{272, mk(15, 5, 0, 1, 1, 1, pix_of(13, 5))};
    tab[15] = '{324, mk(0, 0, 0, 1, 1, 0, 0)};
    tab[16] = '{325, mk(0, 0, 1, 1, 1, 0, 0)};
    tab[17] = '{327, mk(0, 0, 0, 0, 0, 0, 0)};

    hold_rst(3);
    for (int i = 0; i < 18; i++) begin
      if (tab[i].n > n) run(tab[i].n - n, 1'b0);
      check($sformatf("vec%0d", i), tab[i].exp);
    end

    // Two whole frames: fixed pulse counts per window.
    fs_cnt = 0;
    vs_cnt = 0;
    run(2 * HT * VT, 1'b1);
    checks++;
    if (fs_cnt != 2) begin
      errors++;
      $display("FAIL fs_count: got %0d expected 2", fs_cnt);
    end
    checks++;
    if (vs_cnt != 2 * VS * HT) begin
      errors++;
      $display("FAIL vs_count: got %0d expected %0d", vs_cnt, 2 * VS * HT);
    end

    // Mid-frame reset at line 8, column 12.
    while (n % (HT * VT) != 8 * HT + 12) run(1, 1'b1);
    hold_rst(3);
    run(HT * VT + 5, 1'b1);

    for (int k = 0; k < 8; k++) begin
      run($urandom_range(20, 700), 1'b1);
      hold_rst($urandom_range(1, 3));
    end
    run(HT * VT, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
